// File: rtl/trace_capture_ctrl_pkg.sv
// Shared definitions for the trace capture sequencer.
// - cap_state_e  : 2-bit sequencer state encoding (also read back by the register block)
// - TRIG_SRC_*   : trigger source select codes, shared with the register decode
// - trig_select  : resolves the armed trigger condition from the selected source
package trace_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_CAPTURING = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  localparam logic [1:0] TRIG_SRC_M3          = 2'd0;
  localparam logic [1:0] TRIG_SRC_MATCH       = 2'd1;
  localparam logic [1:0] TRIG_SRC_SW          = 2'd2;
  localparam logic [1:0] TRIG_SRC_M3_OR_MATCH = 2'd3;

  function automatic logic trig_select(input logic [1:0] src,
                                       input logic       m3_rise,
                                       input logic       match,
                                       input logic       sw);
    logic hit;
    case (src)
      TRIG_SRC_M3:    hit = m3_rise;
      TRIG_SRC_MATCH: hit = match;
      TRIG_SRC_SW:    hit = sw;
      default:        hit = m3_rise | match;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/trace_capture_ctrl_trig_pulse_gen.sv
// Stretched trigger pulse generator.
// A start request produces a registered pulse lasting len+1 cycles, beginning
// the cycle after start. A later start restarts the count; kill drops it at once.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       one-cycle request to (re)start the pulse
//   kill        one-cycle request to end the pulse immediately (wins over start)
//   len         pulse length minus one
//   O_pulse     registered pulse output
module trace_capture_ctrl_trig_pulse_gen #(
  parameter int pPULSE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    kill,
  input  logic [pPULSE_WIDTH-1:0] len,
  output logic                    O_pulse
);

  logic [pPULSE_WIDTH-1:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O_pulse <= 1'b0;
      remain  <= '0;
    end else if (kill) begin
      O_pulse <= 1'b0;
      remain  <= '0;
    end else if (start) begin
      O_pulse <= 1'b1;
      remain  <= len;
    end else if (O_pulse) begin
      // remain counts the high cycles still owed after the current one
      if (remain == '0) begin
        O_pulse <= 1'b0;
      end else begin
        remain <= remain - pPULSE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm -> wait for trigger -> capture -> done.
// Gates trace-event writes into the capture FIFO, drives the stretched trigger
// pulse, and stops capture on event limit, time limit, FIFO overflow or abort.
// Ports:
//   trace_clk, reset_n      clock and asynchronous active-low reset
//   I_arm/I_abort/I_sw_trig one-cycle host requests
//   I_trig_src              trigger source select (TRIG_SRC_*)
//   I_m3_trig               target trigger level, rising edge detected here
//   I_match_hit/I_match_mask per-rule pattern-match pulses and enables
//   I_max_events/I_max_time capture limits, 0 = unlimited
//   I_pulse_len             trigger pulse length minus one
//   I_event_valid/I_fifo_full trace event and FIFO backpressure
//   O_fifo_wr               FIFO write enable (combinational)
//   O_arm/O_capturing/O_done state indications
//   O_overflow              sticky lost-event flag
//   O_trig_out              stretched trigger pulse
//   O_event_count           events written in this capture
//
// state        | meaning
// ST_IDLE      | waiting for arm
// ST_ARMED     | waiting for the selected trigger condition
// ST_CAPTURING | writing trace events, counting time
// ST_DONE      | capture stopped, final count held until arm/abort
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int pMATCH_RULES = 8,
  parameter int pCOUNT_WIDTH = 16,
  parameter int pTIME_WIDTH  = 32,
  parameter int pPULSE_WIDTH = 8
) (
  input  logic                    trace_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic                    I_abort,
  input  logic                    I_sw_trig,
  input  logic [1:0]              I_trig_src,
  input  logic                    I_m3_trig,
  input  logic [pMATCH_RULES-1:0] I_match_hit,
  input  logic [pMATCH_RULES-1:0] I_match_mask,
  input  logic [pCOUNT_WIDTH-1:0] I_max_events,
  input  logic [pTIME_WIDTH-1:0]  I_max_time,
  input  logic [pPULSE_WIDTH-1:0] I_pulse_len,
  input  logic                    I_event_valid,
  input  logic                    I_fifo_full,
  output logic                    O_fifo_wr,
  output logic                    O_arm,
  output logic                    O_capturing,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic                    O_trig_out,
  output logic [pCOUNT_WIDTH-1:0] O_event_count
);

  cap_state_e              state;
  logic                    m3_q;
  logic [pTIME_WIDTH-1:0]  time_cnt;
  logic [pCOUNT_WIDTH-1:0] event_count;
  logic                    overflow;

  logic                    m3_rise;
  logic                    match;
  logic                    trig;
  logic                    capturing;
  logic                    wr;
  logic                    ovf_now;
  logic [pCOUNT_WIDTH-1:0] count_inc;
  logic                    ev_stop;
  logic                    tm_stop;
  logic                    pulse_start;

  assign m3_rise   = I_m3_trig & ~m3_q;
  assign match     = |(I_match_hit & I_match_mask);
  assign trig      = trig_select(I_trig_src, m3_rise, match, I_sw_trig);
  assign capturing = (state == ST_CAPTURING);

  // Abort suppresses both the write and the overflow flag in its cycle.
  assign wr        = capturing & I_event_valid & ~I_fifo_full & ~I_abort;
  assign ovf_now   = capturing & I_event_valid &  I_fifo_full & ~I_abort;
  assign count_inc = event_count + pCOUNT_WIDTH'(1);

  // The limiting write is itself performed; the stop takes effect next cycle.
  assign ev_stop = wr & (I_max_events != '0) & (count_inc == I_max_events);
  // time_cnt is 0 in the first capture cycle, so stopping at max-1 yields max cycles.
  assign tm_stop = (I_max_time != '0) & (time_cnt == I_max_time - pTIME_WIDTH'(1));

  assign pulse_start = (state == ST_ARMED) & trig & ~I_abort;

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      m3_q        <= 1'b0;
      time_cnt    <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      m3_q <= I_m3_trig;
      if (I_abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (I_arm) begin
              state       <= ST_ARMED;
              event_count <= '0;
              time_cnt    <= '0;
              overflow    <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (trig) state <= ST_CAPTURING;
          end
          ST_CAPTURING: begin
            time_cnt <= time_cnt + pTIME_WIDTH'(1);
            if (wr)      event_count <= count_inc;
            if (ovf_now) overflow    <= 1'b1;
            if (ev_stop | tm_stop | ovf_now) state <= ST_DONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  trace_capture_ctrl_trig_pulse_gen #(
    .pPULSE_WIDTH(pPULSE_WIDTH)
  ) u_trig_pulse_gen (
    .clk     (trace_clk),
    .rst_n   (reset_n),
    .start   (pulse_start),
    .kill    (I_abort),
    .len     (I_pulse_len),
    .O_pulse (O_trig_out)
  );

  assign O_fifo_wr     = wr;
  assign O_arm         = (state == ST_ARMED);
  assign O_capturing   = capturing;
  assign O_done        = (state == ST_DONE);
  assign O_overflow    = overflow;
  assign O_event_count = event_count;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
module tb_trace_capture_ctrl;
  import trace_capture_ctrl_pkg::*;

  logic        trace_clk;
  logic        reset_n;
  logic        arm, abort, sw_trig, m3_trig, event_valid, fifo_full;
  logic [1:0]  trig_src;
  logic [7:0]  match_hit, match_mask, pulse_len;
  logic [15:0] max_events;
  logic [31:0] max_time;
  logic        fifo_wr, o_arm, capturing, done, overflow, trig_out;
  logic [15:0] event_count;

  trace_capture_ctrl dut (
    .trace_clk     (trace_clk),
    .reset_n       (reset_n),
    .I_arm         (arm),
    .I_abort       (abort),
    .I_sw_trig     (sw_trig),
    .I_trig_src    (trig_src),
    .I_m3_trig     (m3_trig),
    .I_match_hit   (match_hit),
    .I_match_mask  (match_mask),
    .I_max_events  (max_events),
    .I_max_time    (max_time),
    .I_pulse_len   (pulse_len),
    .I_event_valid (event_valid),
    .I_fifo_full   (fifo_full),
    .O_fifo_wr     (fifo_wr),
    .O_arm         (o_arm),
    .O_capturing   (capturing),
    .O_done        (done),
    .O_overflow    (overflow),
    .O_trig_out    (trig_out),
    .O_event_count (event_count)
  );

  initial begin
    trace_clk = 1'b0;
    forever #5 trace_clk = ~trace_clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to just after the next rising edge and drop one-cycle requests.
  task automatic next_cycle();
    @(posedge trace_clk);
    #1;
    arm       = 1'b0;
    abort     = 1'b0;
    sw_trig   = 1'b0;
    match_hit = '0;
  endtask

  task automatic sample();
    @(negedge trace_clk);
  endtask

  int hi, writes, last_wr, done_at, cap_cycles;

  initial begin
    reset_n = 1'b0; arm = 0; abort = 0; sw_trig = 0; m3_trig = 0;
    event_valid = 0; fifo_full = 0; trig_src = TRIG_SRC_M3;
    match_hit = '0; match_mask = '0; pulse_len = 8'd3;
    max_events = '0; max_time = '0;

    // Reset state
    #12;
    expect_v("rst_fifo_wr", 0);   check(32'(fifo_wr));
    expect_v("rst_arm", 0);       check(32'(o_arm));
    expect_v("rst_capturing", 0); check(32'(capturing));
    expect_v("rst_done", 0);      check(32'(done));
    expect_v("rst_overflow", 0);  check(32'(overflow));
    expect_v("rst_trig_out", 0);  check(32'(trig_out));
    expect_v("rst_count", 0);     check(32'(event_count));
    next_cycle(); reset_n = 1'b1;

    // m3 rising-edge trigger and pulse length
    next_cycle(); arm = 1'b1; sample();
    expect_v("t1_arm_same_cycle", 0); check(32'(o_arm));
    next_cycle(); sample();
    expect_v("t1_armed", 1); check(32'(o_arm));
    repeat (3) next_cycle();
    next_cycle(); m3_trig = 1'b1; sample();
    expect_v("t1_cap_not_yet", 0); check(32'(capturing));
    next_cycle(); sample();
    expect_v("t1_arm_drop", 0);    check(32'(o_arm));
    expect_v("t1_capturing", 1);   check(32'(capturing));
    expect_v("t1_pulse_cycles", 4);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (trig_out) hi++;
      next_cycle(); sample();
    end
    check(32'(hi));
    next_cycle(); abort = 1'b1; m3_trig = 1'b0;
    next_cycle(); sample();
    expect_v("t1_abort_idle", 0); check(32'(capturing));

    // Event limit: 10 writes, done one cycle after the 10th
    max_events = 16'd10; trig_src = TRIG_SRC_SW;
    next_cycle(); arm = 1'b1;
    next_cycle(); sw_trig = 1'b1; event_valid = 1'b1; sample();
    expect_v("t2_no_wr_trig_cycle", 0); check(32'(fifo_wr));
    expect_v("t2_writes", 10);
    expect_v("t2_done_latency", 1);
    expect_v("t2_count", 10);
    expect_v("t2_done_held", 1);
    writes = 0; last_wr = -1; done_at = -1;
    for (int i = 0; i < 30; i++) begin
      next_cycle(); sample();
      if (fifo_wr) begin writes++; last_wr = i; end
      if (done && done_at < 0) done_at = i;
    end
    check(32'(writes));
    check(32'(done_at - last_wr));
    check(32'(event_count));
    check(32'(done));
    event_valid = 1'b0;

    // Time limit: exactly 100 capture cycles
    max_events = '0; max_time = 32'd100;
    next_cycle(); arm = 1'b1;
    next_cycle(); sw_trig = 1'b1;
    expect_v("t3_cap_cycles", 100);
    expect_v("t3_done", 1);
    expect_v("t3_overflow", 0);
    cap_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      next_cycle(); sample();
      if (capturing) cap_cycles++;
      if (done) break;
    end
    check(32'(cap_cycles));
    check(32'(done));
    check(32'(overflow));

    // Overflow on the 7th event; re-arm clears flag and count
    max_time = '0;
    next_cycle(); arm = 1'b1;
    next_cycle(); sw_trig = 1'b1;
    writes = 0;
    for (int i = 0; i < 7; i++) begin
      next_cycle(); event_valid = 1'b1; fifo_full = (i == 6); sample();
      if (fifo_wr) writes++;
    end
    next_cycle(); event_valid = 1'b0; fifo_full = 1'b0; sample();
    expect_v("t4_writes", 6);   check(32'(writes));
    expect_v("t4_done", 1);     check(32'(done));
    expect_v("t4_overflow", 1); check(32'(overflow));
    expect_v("t4_count", 6);    check(32'(event_count));
    next_cycle(); arm = 1'b1;
    next_cycle(); sample();
    expect_v("t4_rearm_ovf", 0);   check(32'(overflow));
    expect_v("t4_rearm_count", 0); check(32'(event_count));
    expect_v("t4_rearm_arm", 1);   check(32'(o_arm));

    // Masked match trigger
    trig_src = TRIG_SRC_MATCH; match_mask = 8'h04;
    next_cycle(); match_hit = 8'h01;
    next_cycle(); sample();
    expect_v("t5_masked_armed", 1); check(32'(o_arm));
    expect_v("t5_masked_nocap", 0); check(32'(capturing));
    next_cycle(); match_hit = 8'h04;
    next_cycle(); sample();
    expect_v("t5_hit_cap", 1);  check(32'(capturing));
    expect_v("t5_hit_trig", 1); check(32'(trig_out));

    // Abort + arm while capturing
    next_cycle(); abort = 1'b1; arm = 1'b1; event_valid = 1'b1; sample();
    expect_v("t6_abort_no_wr", 0);    check(32'(fifo_wr));
    expect_v("t6_pulse_running", 1);  check(32'(trig_out));
    next_cycle(); sample();
    expect_v("t6_idle_arm", 0);       check(32'(o_arm));
    expect_v("t6_idle_cap", 0);       check(32'(capturing));
    expect_v("t6_idle_done", 0);      check(32'(done));
    expect_v("t6_pulse_killed", 0);   check(32'(trig_out));
    expect_v("t6_idle_no_wr", 0);     check(32'(fifo_wr));

    // Asynchronous reset mid-capture
    trig_src = TRIG_SRC_SW; event_valid = 1'b0;
    next_cycle(); arm = 1'b1;
    next_cycle(); sw_trig = 1'b1; event_valid = 1'b1;
    repeat (3) next_cycle();
    expect_v("t7_pre_count", 2); check(32'(event_count));
    expect_v("t7_pre_wr", 1);    check(32'(fifo_wr));
    #2 reset_n = 1'b0;
    #1;
    expect_v("t7_rst_wr", 0);    check(32'(fifo_wr));
    expect_v("t7_rst_cap", 0);   check(32'(capturing));
    expect_v("t7_rst_trig", 0);  check(32'(trig_out));
    expect_v("t7_rst_count", 0); check(32'(event_count));
    expect_v("t7_rst_ovf", 0);   check(32'(overflow));
    expect_v("t7_rst_done", 0);  check(32'(done));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
